// File: rtl/cart_sram_arbiter.sv
// Arbitrates the cartridge save SRAM between the Game Boy bus (always first) and a host port.
// Host cycles run only while the GB is off the A000-BFFF window and are aborted and retried if it starts.
module cart_sram_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int ACC_CYCLES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       GB_A,
  input  logic              GB_CS,
  input  logic              GB_RD,
  input  logic              GB_WR,
  input  logic [7:0]        GB_D_IN,
  output logic [7:0]        GB_D_OUT,
  output logic              GB_D_OE,
  input  logic              GB_RAM_EN,
  input  logic [3:0]        RAM_BANK,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [7:0]        HOST_WDATA,
  output logic              HOST_ACK,
  output logic [7:0]        HOST_RDATA,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [7:0]        SRAM_DQ_IN,
  output logic [7:0]        SRAM_DQ_OUT,
  output logic              SRAM_DQ_OE,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GB_ACC,
    S_HOST_ACC,
    S_HOST_ABORT,
    S_HOST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0]   cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]   rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0]   wr_sync_q, wr_sync_d;
  logic [3*SYNC_STAGES-1:0] a_sync_q, a_sync_d;

  logic              cs_s, rd_s, wr_s;
  logic [2:0]        a_s;
  logic              gb_sel, gb_strb;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              host_we_q, host_we_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [7:0]        sram_dq_out_q, sram_dq_out_d;
  logic              sram_dq_oe_q, sram_dq_oe_d;
  logic              sram_ce_n_q, sram_ce_n_d;
  logic              sram_oe_n_q, sram_oe_n_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic [7:0]        gb_d_out_q, gb_d_out_d;
  logic              gb_d_oe_q, gb_d_oe_d;
  logic              host_ack_q, host_ack_d;
  logic [7:0]        host_rdata_q, host_rdata_d;

  // New samples enter at bit 0; the oldest stage is the one the logic uses.
  always_comb begin
    cs_sync_d = SYNC_STAGES'({cs_sync_q, GB_CS});
    rd_sync_d = SYNC_STAGES'({rd_sync_q, GB_RD});
    wr_sync_d = SYNC_STAGES'({wr_sync_q, GB_WR});
    a_sync_d  = (3*SYNC_STAGES)'({a_sync_q, GB_A[15:13]});
  end

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign rd_s    = rd_sync_q[SYNC_STAGES-1];
  assign wr_s    = wr_sync_q[SYNC_STAGES-1];
  assign a_s     = a_sync_q[3*SYNC_STAGES-1 -: 3];
  assign gb_sel  = ~cs_s & (a_s == 3'b101) & GB_RAM_EN;
  assign gb_strb = gb_sel & (~rd_s | ~wr_s);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gb_strb)       state_d = S_GB_ACC;
        else if (HOST_REQ) state_d = S_HOST_ACC;
      end
      S_GB_ACC:     if (!gb_strb) state_d = S_IDLE;
      S_HOST_ACC: begin
        if (gb_strb)               state_d = S_HOST_ABORT;
        else if (cnt_q == '0)      state_d = S_HOST_DONE;
      end
      S_HOST_ABORT: state_d = gb_strb ? S_GB_ACC : S_IDLE;
      S_HOST_DONE:  state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so every pin is a flop.
  always_comb begin
    cnt_d         = cnt_q;
    host_we_d     = host_we_q;
    sram_a_d      = sram_a_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = 1'b0;
    sram_ce_n_d   = 1'b1;
    sram_oe_n_d   = 1'b1;
    sram_we_n_d   = 1'b1;
    gb_d_oe_d     = 1'b0;
    host_ack_d    = 1'b0;
    host_rdata_d  = host_rdata_q;
    gb_d_out_d    = (state_q == S_GB_ACC && !sram_oe_n_q) ? SRAM_DQ_IN : gb_d_out_q;
    case (state_d)
      S_GB_ACC: begin
        sram_a_d      = ADDR_W'({RAM_BANK, GB_A[12:0]});
        sram_ce_n_d   = 1'b0;
        sram_oe_n_d   = rd_s;
        sram_we_n_d   = wr_s;
        sram_dq_out_d = GB_D_IN;
        sram_dq_oe_d  = ~wr_s;
        gb_d_oe_d     = ~rd_s;
      end
      S_HOST_ACC: begin
        // Entry is always from IDLE, including the retry after an abort.
        if (state_q != S_HOST_ACC) begin
          host_we_d     = HOST_WE;
          sram_a_d      = HOST_ADDR;
          sram_dq_out_d = HOST_WDATA;
          cnt_d         = CNT_W'(ACC_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        sram_ce_n_d  = 1'b0;
        sram_oe_n_d  = host_we_d;
        sram_we_n_d  = ~host_we_d;
        sram_dq_oe_d = host_we_d;
      end
      S_HOST_DONE: begin
        sram_ce_n_d  = 1'b0;
        sram_dq_oe_d = host_we_q;
        host_ack_d   = 1'b1;
        if (!host_we_q) host_rdata_d = SRAM_DQ_IN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_sync_q     <= '1;
      rd_sync_q     <= '1;
      wr_sync_q     <= '1;
      a_sync_q      <= '0;
      cnt_q         <= '0;
      host_we_q     <= 1'b0;
      sram_a_q      <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_ce_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_we_n_q   <= 1'b1;
      gb_d_out_q    <= '0;
      gb_d_oe_q     <= 1'b0;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      rd_sync_q     <= rd_sync_d;
      wr_sync_q     <= wr_sync_d;
      a_sync_q      <= a_sync_d;
      cnt_q         <= cnt_d;
      host_we_q     <= host_we_d;
      sram_a_q      <= sram_a_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_ce_n_q   <= sram_ce_n_d;
      sram_oe_n_q   <= sram_oe_n_d;
      sram_we_n_q   <= sram_we_n_d;
      gb_d_out_q    <= gb_d_out_d;
      gb_d_oe_q     <= gb_d_oe_d;
      host_ack_q    <= host_ack_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign SRAM_A      = sram_a_q;
  assign SRAM_DQ_OUT = sram_dq_out_q;
  assign SRAM_DQ_OE  = sram_dq_oe_q;
  assign SRAM_CE_N   = sram_ce_n_q;
  assign SRAM_OE_N   = sram_oe_n_q;
  assign SRAM_WE_N   = sram_we_n_q;
  assign GB_D_OUT    = gb_d_out_q;
  assign GB_D_OE     = gb_d_oe_q;
  assign HOST_ACK    = host_ack_q;
  assign HOST_RDATA  = host_rdata_q;

endmodule

// File: tb/tb_cart_sram_arbiter.sv
// Bench for cart_sram_arbiter: behavioural SRAM, host driver, and a queue of expected read data.
module tb_cart_sram_arbiter;
  localparam int ADDR_W      = 17;
  localparam int ACC_CYCLES  = 3;
  localparam int SYNC_STAGES = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [15:0]       GB_A;
  logic              GB_CS, GB_RD, GB_WR;
  logic [7:0]        GB_D_IN;
  logic [7:0]        GB_D_OUT;
  logic              GB_D_OE;
  logic              GB_RAM_EN;
  logic [3:0]        RAM_BANK;
  logic              HOST_REQ, HOST_WE;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [7:0]        HOST_WDATA;
  logic              HOST_ACK;
  logic [7:0]        HOST_RDATA;
  logic [ADDR_W-1:0] SRAM_A;
  logic [7:0]        SRAM_DQ_IN, SRAM_DQ_OUT;
  logic              SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  cart_sram_arbiter #(.ADDR_W(ADDR_W), .ACC_CYCLES(ACC_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK), .RST(RST), .GB_A(GB_A), .GB_CS(GB_CS), .GB_RD(GB_RD), .GB_WR(GB_WR),
    .GB_D_IN(GB_D_IN), .GB_D_OUT(GB_D_OUT), .GB_D_OE(GB_D_OE), .GB_RAM_EN(GB_RAM_EN),
    .RAM_BANK(RAM_BANK), .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
    .HOST_WDATA(HOST_WDATA), .HOST_ACK(HOST_ACK), .HOST_RDATA(HOST_RDATA), .SRAM_A(SRAM_A),
    .SRAM_DQ_IN(SRAM_DQ_IN), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  assign SRAM_DQ_IN = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_A] : 8'h00;
  always @(posedge CLK)
    if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE) mem[SRAM_A] <= SRAM_DQ_OUT;

  task automatic host_access(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] wdata,
                             output int lat, output int oe_low, output int we_low,
                             output logic got_ack, output logic ack_after);
    @(negedge CLK);
    HOST_REQ = 1'b1; HOST_WE = we; HOST_ADDR = addr; HOST_WDATA = wdata;
    lat = 0; oe_low = 0; we_low = 0; got_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (!SRAM_OE_N) oe_low++;
      if (!SRAM_WE_N) we_low++;
      if (HOST_ACK) begin got_ack = 1'b1; break; end
    end
    HOST_REQ = 1'b0;
    @(posedge CLK); #1;
    ack_after = HOST_ACK;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE, GB_D_OE, HOST_ACK} !== 6'b111000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 111000",
                         {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE, GB_D_OE, HOST_ACK});
    end
    checks++;
    if (HOST_RDATA !== 8'h00 || GB_D_OUT !== 8'h00 || SRAM_A !== '0) begin
      errors++; $display("FAIL reset_data: rdata=%h gbd=%h a=%h expected 00 00 0", HOST_RDATA, GB_D_OUT, SRAM_A);
    end
    HOST_REQ = 1'b0;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_host_read();
    int lat, oe_low, we_low; logic got, after; logic [7:0] e;
    host_access(1'b1, 17'h01234, 8'h5A, lat, oe_low, we_low, got, after);
    checks++;
    if (!got || we_low != ACC_CYCLES) begin
      errors++; $display("FAIL host_write_strobe: ack=%b we_low=%0d expected 1 %0d", got, we_low, ACC_CYCLES);
    end
    exp_q.push_back(8'h5A);
    host_access(1'b0, 17'h01234, 8'h00, lat, oe_low, we_low, got, after);
    checks++;
    if (!got || lat != ACC_CYCLES + 1) begin
      errors++; $display("FAIL host_read_latency: ack=%b lat=%0d expected 1 %0d", got, lat, ACC_CYCLES + 1);
    end
    checks++;
    if (oe_low != ACC_CYCLES || we_low != 0) begin
      errors++; $display("FAIL host_read_oe: oe_low=%0d we_low=%0d expected %0d 0", oe_low, we_low, ACC_CYCLES);
    end
    checks++;
    if (after !== 1'b0) begin errors++; $display("FAIL ack_pulse_width: ack next cycle=%b expected 0", after); end
    e = exp_q.pop_front();
    checks++;
    if (HOST_RDATA !== e) begin errors++; $display("FAIL host_read_data: got %h expected %h", HOST_RDATA, e); end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (HOST_RDATA !== 8'h5A) begin errors++; $display("FAIL rdata_hold: got %h expected 5a", HOST_RDATA); end
  endtask

  task automatic test_gb_write();
    int n; int lat, oe_low, we_low; logic got, after; logic [7:0] e;
    @(negedge CLK);
    GB_RAM_EN = 1'b1; RAM_BANK = 4'd2; GB_A = 16'hA010; GB_D_IN = 8'hC3; GB_CS = 1'b0; GB_WR = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1; n++;
      if (!SRAM_WE_N) break;
    end
    checks++;
    if (n != SYNC_STAGES + 1 || SRAM_WE_N !== 1'b0) begin
      errors++; $display("FAIL gb_we_delay: edges=%0d we_n=%b expected %0d 0", n, SRAM_WE_N, SYNC_STAGES + 1);
    end
    checks++;
    if (SRAM_A !== 17'h04010 || SRAM_DQ_OE !== 1'b1 || SRAM_CE_N !== 1'b0 || SRAM_OE_N !== 1'b1) begin
      errors++; $display("FAIL gb_write_pins: a=%h oe=%b ce_n=%b oe_n=%b expected 04010 1 0 1",
                         SRAM_A, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N);
    end
    @(negedge CLK); GB_WR = 1'b1; GB_CS = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if (SRAM_WE_N !== 1'b1 || SRAM_CE_N !== 1'b1 || mem[17'h04010] !== 8'hC3) begin
      errors++; $display("FAIL gb_write_done: we_n=%b ce_n=%b mem=%h expected 1 1 c3",
                         SRAM_WE_N, SRAM_CE_N, mem[17'h04010]);
    end
    exp_q.push_back(8'hC3);
    host_access(1'b0, 17'h04010, 8'h00, lat, oe_low, we_low, got, after);
    e = exp_q.pop_front();
    checks++;
    if (!got || HOST_RDATA !== e) begin errors++; $display("FAIL gb_write_readback: got %h expected %h", HOST_RDATA, e); end
  endtask

  task automatic test_ram_disabled();
    int bad; int lat, oe_low, we_low; logic got, after; logic [7:0] e;
    @(negedge CLK);
    GB_RAM_EN = 1'b0; RAM_BANK = 4'd0; GB_A = 16'hA000; GB_CS = 1'b0; GB_RD = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (SRAM_CE_N !== 1'b1 || GB_D_OE !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ram_en_off_idle: active cycles=%0d expected 0", bad); end
    host_access(1'b1, 17'h1FFFF, 8'h3C, lat, oe_low, we_low, got, after);
    exp_q.push_back(8'h3C);
    host_access(1'b0, 17'h1FFFF, 8'h00, lat, oe_low, we_low, got, after);
    e = exp_q.pop_front();
    checks++;
    if (!got || HOST_RDATA !== e) begin errors++; $display("FAIL ram_en_off_host: ack=%b got %h expected %h", got, HOST_RDATA, e); end
    @(negedge CLK); GB_CS = 1'b1; GB_RD = 1'b1; GB_RAM_EN = 1'b1;
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_abort();
    int lat, oe_low, we_low, acks; logic got, after; logic seen;
    host_access(1'b1, 17'h02100, 8'h77, lat, oe_low, we_low, got, after);
    host_access(1'b1, 17'h00000, 8'h11, lat, oe_low, we_low, got, after);
    @(negedge CLK);
    RAM_BANK = 4'd1; GB_A = 16'hA100;
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 17'h00000; HOST_WDATA = 8'hFF;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (!SRAM_WE_N) begin seen = 1'b1; break; end
    end
    GB_CS = 1'b0; GB_RD = 1'b0;
    acks = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK); #1;
      if (HOST_ACK) acks++;
      if (i == 3) begin
        checks++;
        if (!seen || SRAM_CE_N !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0) begin
          errors++; $display("FAIL abort_gap: ce_n=%b we_n=%b dq_oe=%b expected 1 1 0", SRAM_CE_N, SRAM_WE_N, SRAM_DQ_OE);
        end
      end
      if (i == 4) begin
        checks++;
        if (SRAM_OE_N !== 1'b0 || SRAM_A !== 17'h02100) begin
          errors++; $display("FAIL abort_gb_acc: oe_n=%b a=%h expected 0 02100", SRAM_OE_N, SRAM_A);
        end
      end
    end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (GB_D_OUT !== 8'h77 || GB_D_OE !== 1'b1) begin
      errors++; $display("FAIL abort_gb_read: d=%h oe=%b expected 77 1", GB_D_OUT, GB_D_OE);
    end
    @(negedge CLK); GB_RD = 1'b1; GB_CS = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (HOST_ACK) begin acks++; HOST_REQ = 1'b0; end
    end
    checks++;
    if (acks != 1 || mem[17'h00000] !== 8'hFF) begin
      errors++; $display("FAIL abort_retry: acks=%0d mem=%h expected 1 ff", acks, mem[17'h00000]);
    end
  endtask

  task automatic test_same_cycle();
    int lat, oe_low, we_low, acks, n; logic got, after; logic [7:0] e;
    host_access(1'b1, 17'h06055, 8'h99, lat, oe_low, we_low, got, after);
    @(negedge CLK);
    RAM_BANK = 4'd3; GB_A = 16'hA055; GB_CS = 1'b0; GB_RD = 1'b0;
    repeat (SYNC_STAGES) @(posedge CLK);
    #1;
    HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = 17'h01234;
    exp_q.push_back(8'h5A);
    @(posedge CLK); #1;
    checks++;
    if (SRAM_OE_N !== 1'b0 || SRAM_A !== 17'h06055) begin
      errors++; $display("FAIL same_cycle_gb_first: oe_n=%b a=%h expected 0 06055", SRAM_OE_N, SRAM_A);
    end
    acks = 0;
    repeat (4) begin @(posedge CLK); #1; if (HOST_ACK) acks++; end
    checks++;
    if (acks != 0 || GB_D_OUT !== 8'h99) begin
      errors++; $display("FAIL same_cycle_gb_read: acks=%0d d=%h expected 0 99", acks, GB_D_OUT);
    end
    @(negedge CLK); GB_RD = 1'b1; GB_CS = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1; n++;
      if (HOST_ACK) begin got = 1'b1; break; end
    end
    HOST_REQ = 1'b0;
    checks++;
    if (!got || n != SYNC_STAGES + 1 + ACC_CYCLES + 1) begin
      errors++; $display("FAIL same_cycle_host_after: ack=%b edges=%0d expected 1 %0d", got, n, SYNC_STAGES + ACC_CYCLES + 2);
    end
    e = exp_q.pop_front();
    checks++;
    if (HOST_RDATA !== e) begin errors++; $display("FAIL same_cycle_data: got %h expected %h", HOST_RDATA, e); end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_reset_mid();
    int acks; logic seen;
    @(negedge CLK);
    HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 17'h00200; HOST_WDATA = 8'hAB;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (!SRAM_WE_N) begin seen = 1'b1; break; end
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (!seen || SRAM_WE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0 || HOST_ACK !== 1'b0 || SRAM_CE_N !== 1'b1) begin
      errors++; $display("FAIL reset_mid_access: we_n=%b dq_oe=%b ack=%b ce_n=%b expected 1 0 0 1",
                         SRAM_WE_N, SRAM_DQ_OE, HOST_ACK, SRAM_CE_N);
    end
    HOST_REQ = 1'b0; RST = 1'b0;
    acks = 0;
    repeat (6) begin @(posedge CLK); #1; if (HOST_ACK || !SRAM_CE_N) acks++; end
    checks++;
    if (acks != 0 || HOST_RDATA !== 8'h00) begin
      errors++; $display("FAIL reset_mid_idle: activity=%0d rdata=%h expected 0 00", acks, HOST_RDATA);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [4];
    logic [7:0] data [4];
    int lat, oe_low, we_low; logic got, after; logic [7:0] e;
    addrs[0] = 17'h10000; addrs[1] = 17'h0ABCD; addrs[2] = 17'h1FFFE; addrs[3] = 17'h00001;
    for (int i = 0; i < 4; i++) begin
      data[i] = 8'($urandom_range(0, 255));
      host_access(1'b1, addrs[i], data[i], lat, oe_low, we_low, got, after);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(data[i]);
      host_access(1'b0, addrs[i], 8'h00, lat, oe_low, we_low, got, after);
      e = exp_q.pop_front();
      checks++;
      if (!got || lat != ACC_CYCLES + 1 || HOST_RDATA !== e) begin
        errors++; $display("FAIL b2b_read[%0d]: ack=%b lat=%0d data=%h expected 1 %0d %h",
                           i, got, lat, HOST_RDATA, ACC_CYCLES + 1, e);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    GB_A = 16'h0000; GB_CS = 1'b1; GB_RD = 1'b1; GB_WR = 1'b1; GB_D_IN = 8'h00;
    GB_RAM_EN = 1'b1; RAM_BANK = 4'd0;
    HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = 8'h00;
    test_reset();
    test_host_read();
    test_gb_write();
    test_ram_disabled();
    test_abort();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
